vga_timing: RTL and testbench
=============================

Name: vga_timing

Overview:
- Generates the raster scan for the VGA output path: horizontal/vertical pixel counters, sync pulses and an active-video flag.
- Feeds the x/y coordinates consumed by the rectangle hit-test stage and the pixel colour mux.
- The default timing is 640x480@60 Hz with a 25 MHz pixel rate.
- All outputs are registered and mutually aligned, so downstream combinational hit logic sees a consistent (x, y, active) triple every pixel.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  input  1  system clock; one pixel per pix_en cycle
- rst  input  1  asynchronous, active-high reset
- x  output  11  current pixel column (raw horizontal count, 0..H_TOTAL-1)
- y  output  11  current line (raw vertical count, 0..V_TOTAL-1)
- hsync  output  1  horizontal sync, level per SYNC_POL
- vsync  output  1  vertical sync, level per SYNC_POL
- active  output  1  1 when x<H_ACTIVE and y<V_ACTIVE
- pix_en  output  1  1 in cycles where outputs present a new pixel
- frame_start  output  1  single-cycle pulse when outputs present (0,0)

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Reset is asynchronous and active-high (rst); polarity and synchronicity are fixed.
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
  - Both must be ≤2047; all arithmetic is 11-bit unsigned.
- Internal counters:
  - hcnt, vcnt advance on every pixel tick.
  - Without the optional feature, a pixel tick occurs on every clk cycle.
- Counter rules:
  - hcnt increments.
  - hcnt==H_TOTAL-1 → hcnt=0 and vcnt increments.
  - hcnt==H_TOTAL-1 and vcnt==V_TOTAL-1 → hcnt=0, vcnt=0 (frame wrap).
- Output stage:
  - On each pixel tick, the output registers load decodes of the pre-increment hcnt/vcnt, so outputs lag the counters by exactly one tick.
  - Outputs are mutually aligned: whenever x=N, y=M, hsync/vsync/active/frame_start describe (N,M).
- Decodes:
  - hsync = SYNC_POL when H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL (default: low for x=656..751).
  - vsync = SYNC_POL when V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC, else ~SYNC_POL (default: low for y=490..491, whole lines).
  - active = (x<H_ACTIVE)&&(y<V_ACTIVE).
  - frame_start = 1 for exactly one clk cycle, the cycle outputs show (0,0).
  - pix_en = 1 on output-update cycles; constant 1 after reset without the optional feature.
- Reset values:
  - hcnt=vcnt=0.
  - x=0, y=0, hsync=vsync=~SYNC_POL, active=0, pix_en=0, frame_start=0.
- First ticks after reset:
  - First pixel tick after rst falls: outputs show x=0, y=0, active=1, frame_start=1.
  - Counters then hold 1.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously); the scan restarts from (0,0) as above.
- No external stall or handshake; the scan free-runs.

Optional Feature:
- Macro: VGA_PIX_DIV2_EN.
- Defined:
  - clk is 2× the pixel rate (50 MHz).
  - An internal toggle flop, reset to 0, creates a pixel tick every second clk cycle.
  - Counters and outputs update only on ticks and hold between them.
  - pix_en=1 only in the clk cycle immediately after a tick update.
  - frame_start is asserted only in that cycle, so it remains a single clk cycle.
- Undefined:
  - Every clk cycle is a pixel tick.
  - pix_en=1 every cycle after reset release.
  - No toggle flop is built.

Test Plan:
- Reset: hold rst=1 for 5 cycles → x=0, y=0, hsync=vsync=1, active=0, frame_start=0; first cycle after release → x=0, y=0, active=1, frame_start=1 for one cycle.
- Line timing: run one line → active falls when x goes 639→640; hsync=0 for exactly 96 ticks (x=656..751); after x=799 → x=0, y=1.
- Frame timing: run a full frame → vsync=0 exactly while y=490..491; after (799,524) → (0,0) with frame_start=1; frame period = 420000 ticks.
- Alignment: sample every cycle → hsync/active always match the decode of the simultaneously presented x,y (check at x=655/656, 751/752, 639/640).
- Mid-frame reset: assert rst at (300,200) → outputs go to reset values without waiting for a clock edge; after release, the scan restarts at (0,0) with frame_start.
- With VGA_PIX_DIV2_EN: x advances every 2 clk cycles; pix_en alternates 1/0; frame period = 840000 clk cycles; frame_start is a single clk-cycle pulse.

Source files
------------

// File: rtl/vga_timing.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------------------------
// vga_timing
//
// Raster-scan generator for the VGA output path. Two free-running counters (hcnt, vcnt) walk
// the full H_TOTAL x V_TOTAL raster. On every pixel tick the output registers capture the
// decode of the *pre-increment* counter values, so every output is registered and all of
// them describe the same pixel in the same cycle.
//
// Default timing: 640x480@60 Hz at a 25 MHz pixel rate (800 x 525 raster).
//
// Optional build macro:
//   VGA_PIX_DIV2_EN  clk runs at twice the pixel rate. A toggle flop produces a pixel tick on
//                    every second clk cycle; counters and outputs hold between ticks, and
//                    pix_en / frame_start are high only in the cycle right after an update.
//                    Undefined (default): every clk cycle is a pixel tick.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   x[10:0]      out  current pixel column (raw count, 0..H_TOTAL-1)
//   y[10:0]      out  current line (raw count, 0..V_TOTAL-1)
//   hsync        out  horizontal sync, asserted level = SYNC_POL
//   vsync        out  vertical sync, asserted level = SYNC_POL
//   active       out  1 while (x, y) lies in the visible area
//   pix_en       out  1 in cycles where the outputs present a newly loaded pixel
//   frame_start  out  single-cycle pulse in the cycle the outputs present (0, 0)
//
// H_TOTAL and V_TOTAL must not exceed 2047; all counter arithmetic is 11-bit unsigned.
// ---------------------------------------------------------------------------------------------
module vga_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        pix_en,
  output logic        frame_start
);

  // Raster boundaries, all pre-sized to the 11-bit counter width.
  localparam logic [10:0] HActive   = 11'(H_ACTIVE);
  localparam logic [10:0] HSyncBeg  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSyncEnd  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] HTotal    = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] HLast     = HTotal - 11'd1;

  localparam logic [10:0] VActive   = 11'(V_ACTIVE);
  localparam logic [10:0] VSyncBeg  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSyncEnd  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] VTotal    = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [10:0] VLast     = VTotal - 11'd1;

  localparam logic        SyncIdle  = ~SYNC_POL;

  // -------------------------------------------------------------------------------------------
  // Pixel tick generation
  // -------------------------------------------------------------------------------------------
  logic tick;

`ifdef VGA_PIX_DIV2_EN
  logic tog_q;

  // Toggle starts at 0, so the first tick lands on the second clk edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog_q <= 1'b0;
    end else begin
      tog_q <= ~tog_q;
    end
  end

  assign tick = tog_q;
`else
  assign tick = 1'b1;
`endif

  // -------------------------------------------------------------------------------------------
  // Raster counters
  // -------------------------------------------------------------------------------------------
  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic        h_wrap;
  logic        v_wrap;

  assign h_wrap = (hcnt_q == HLast);
  assign v_wrap = (vcnt_q == VLast);

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick) begin
      if (h_wrap) begin
        hcnt_d = 11'd0;
        vcnt_d = v_wrap ? 11'd0 : vcnt_q + 11'd1;
      end else begin
        hcnt_d = hcnt_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= 11'd0;
      vcnt_q <= 11'd0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Decode of the current (pre-increment) counter position
  // -------------------------------------------------------------------------------------------
  logic in_hsync;
  logic in_vsync;
  logic hsync_d;
  logic vsync_d;
  logic active_d;
  logic origin_d;

  always_comb begin
    in_hsync = (hcnt_q >= HSyncBeg) && (hcnt_q < HSyncEnd);
    in_vsync = (vcnt_q >= VSyncBeg) && (vcnt_q < VSyncEnd);
    hsync_d  = in_hsync ? SYNC_POL : SyncIdle;
    vsync_d  = in_vsync ? SYNC_POL : SyncIdle;
    active_d = (hcnt_q < HActive) && (vcnt_q < VActive);
    origin_d = (hcnt_q == 11'd0) && (vcnt_q == 11'd0);
  end

  // -------------------------------------------------------------------------------------------
  // Output registers: loaded together on each tick so (x, y, sync, active) stay aligned.
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x           <= 11'd0;
      y           <= 11'd0;
      hsync       <= SyncIdle;
      vsync       <= SyncIdle;
      active      <= 1'b0;
      pix_en      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // pix_en marks the cycle right after an update; constant 1 when every cycle ticks.
      pix_en <= tick;
      if (tick) begin
        x           <= hcnt_q;
        y           <= vcnt_q;
        hsync       <= hsync_d;
        vsync       <= vsync_d;
        active      <= active_d;
        frame_start <= origin_d;
      end else begin
        // Outputs hold between ticks, but the frame pulse must stay one clk cycle wide.
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
`timescale 1ns / 1ps
// Testbench for vga_timing: a default-timing instance and a small-raster, active-high-sync
// instance share clock and reset. A tick-count model predicts every output from the raster
// rules; literal expectations pin key boundary points.
module tb_vga_timing;

`ifdef VGA_PIX_DIV2_EN
  localparam bit DIV2 = 1'b1;
`else
  localparam bit DIV2 = 1'b0;
`endif

  // Small raster for the second instance: 32 x 19, vsync on lines 14..16.
  localparam int S_HA = 20, S_HFP = 3, S_HS = 5, S_HBP = 4;
  localparam int S_VA = 12, S_VFP = 2, S_VS = 3, S_VBP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [10:0] d0_x, d0_y, d1_x, d1_y;
  logic d0_hs, d0_vs, d0_act, d0_pe, d0_fs;
  logic d1_hs, d1_vs, d1_act, d1_pe, d1_fs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_timing dut0 (
    .clk        (clk),
    .rst        (rst),
    .x          (d0_x),
    .y          (d0_y),
    .hsync      (d0_hs),
    .vsync      (d0_vs),
    .active     (d0_act),
    .pix_en     (d0_pe),
    .frame_start(d0_fs)
  );

  vga_timing #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .SYNC_POL(1'b1)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .x          (d1_x),
    .y          (d1_y),
    .hsync      (d1_hs),
    .vsync      (d1_vs),
    .active     (d1_act),
    .pix_en     (d1_pe),
    .frame_start(d1_fs)
  );

  // ------------------------------------------------------------------------------------------
  // Model: number of pixel ticks since reset, tick phase, and whether the last edge ticked.
  // ------------------------------------------------------------------------------------------
  int ticks;
  bit tog;
  bit last;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ticks <= 0;
      tog   <= 1'b0;
      last  <= 1'b0;
    end else if (DIV2) begin
      tog   <= ~tog;
      ticks <= ticks + (tog ? 1 : 0);
      last  <= tog;
    end else begin
      ticks <= ticks + 1;
      last  <= 1'b1;
    end
  end

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic        act;
    logic        pe;
    logic        fs;
  } exp_t;

  function automatic exp_t model(input int ha, input int hfp, input int hsw, input int hbp,
                                 input int va, input int vfp, input int vsw, input int vbp,
                                 input bit pol, input int t, input bit lst);
    exp_t e;
    int   p, xx, yy;
    if (t == 0) begin
      e = '{x: 11'd0, y: 11'd0, hs: ~pol, vs: ~pol, act: 1'b0, pe: 1'b0, fs: 1'b0};
    end else begin
      p    = t - 1;
      xx   = p % (ha + hfp + hsw + hbp);
      yy   = (p / (ha + hfp + hsw + hbp)) % (va + vfp + vsw + vbp);
      e.x  = 11'(xx);
      e.y  = 11'(yy);
      e.hs = (xx >= ha + hfp && xx < ha + hfp + hsw) ? pol : ~pol;
      e.vs = (yy >= va + vfp && yy < va + vfp + vsw) ? pol : ~pol;
      e.act = (xx < ha) && (yy < va);
      e.pe  = lst;
      e.fs  = lst && xx == 0 && yy == 0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    exp_t e0, e1;
    e0 = model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, ticks, last);
    e1 = model(S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b1, ticks, last);
    chk("d0_x", d0_x, e0.x);     chk("d0_y", d0_y, e0.y);
    chk("d0_hsync", d0_hs, e0.hs); chk("d0_vsync", d0_vs, e0.vs);
    chk("d0_active", d0_act, e0.act); chk("d0_pix_en", d0_pe, e0.pe);
    chk("d0_frame_start", d0_fs, e0.fs);
    chk("d1_x", d1_x, e1.x);     chk("d1_y", d1_y, e1.y);
    chk("d1_hsync", d1_hs, e1.hs); chk("d1_vsync", d1_vs, e1.vs);
    chk("d1_active", d1_act, e1.act); chk("d1_pix_en", d1_pe, e1.pe);
    chk("d1_frame_start", d1_fs, e1.fs);
  end

  // Advance until the outputs present raster tick index p (0-based since reset release).
  task automatic goto(input int p);
    int n = 0;
    while (ticks != p + 1 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (ticks != p + 1) chk("goto_timeout", ticks, p + 1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    // Reset values (dut1 syncs are active-high, so idle low).
    chk("rst_d0_x", d0_x, 0);      chk("rst_d0_y", d0_y, 0);
    chk("rst_d0_hsync", d0_hs, 1); chk("rst_d0_vsync", d0_vs, 1);
    chk("rst_d0_active", d0_act, 0); chk("rst_d0_fs", d0_fs, 0);
    chk("rst_d0_pix_en", d0_pe, 0);  chk("rst_d1_hsync", d1_hs, 0);
    rst = 1'b0;

    goto(0);
    chk("first_x", d0_x, 0);  chk("first_y", d0_y, 0);
    chk("first_active", d0_act, 1); chk("first_fs", d0_fs, 1);
    chk("first_pix_en", d0_pe, 1);  chk("first_d1_fs", d1_fs, 1);
    goto(1);
    chk("second_fs", d0_fs, 0); chk("second_x", d0_x, 1);

    goto(447); chk("s447_x", d1_x, 31); chk("s447_y", d1_y, 13); chk("s447_vs", d1_vs, 0);
    goto(448); chk("s448_x", d1_x, 0);  chk("s448_y", d1_y, 14); chk("s448_vs", d1_vs, 1);
    goto(543); chk("s543_y", d1_y, 16); chk("s543_vs", d1_vs, 1);
    goto(544); chk("s544_y", d1_y, 17); chk("s544_vs", d1_vs, 0);
    goto(607); chk("s607_x", d1_x, 31); chk("s607_y", d1_y, 18); chk("s607_fs", d1_fs, 0);
    goto(608); chk("s608_x", d1_x, 0);  chk("s608_y", d1_y, 0);  chk("s608_fs", d1_fs, 1);

    goto(639); chk("x639", d0_x, 639); chk("x639_active", d0_act, 1);
    goto(640); chk("x640", d0_x, 640); chk("x640_active", d0_act, 0);
    goto(655); chk("x655_hsync", d0_hs, 1);
    goto(656); chk("x656_hsync", d0_hs, 0);
    goto(751); chk("x751_hsync", d0_hs, 0);
    goto(752); chk("x752_hsync", d0_hs, 1);
    goto(799); chk("x799_x", d0_x, 799); chk("x799_y", d0_y, 0);
    goto(800); chk("line1_x", d0_x, 0);  chk("line1_y", d0_y, 1); chk("line1_act", d0_act, 1);

    // Random run lengths with asynchronous resets dropped mid-cycle.
    for (int it = 0; it < 15; it++) begin
      repeat ($urandom_range(50, 2500)) @(posedge clk);
      if ($urandom_range(0, 2) != 0) begin
        #($urandom_range(1, 3));
        rst = 1'b1;
        #1;
        chk("async_x", d0_x, 0);   chk("async_y", d0_y, 0);
        chk("async_pix_en", d0_pe, 0); chk("async_d1_act", d1_act, 0);
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #($urandom_range(1, 4));
        rst = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
